// File: rtl/btn_conditioner_if.sv
// Signal bundle between the push-button conditioner and its surroundings:
// tick and raw button in, debounced level and count-enable strobes out.
interface btn_conditioner_if;
  // Strobe semantics: every output pulse (press, release_pulse, rep, ce_out)
  // is registered and high for exactly one clk; there is no back-pressure.
  // The consumer samples each strobe on the next rising clk edge.
  // "release" is a reserved word, so the falling-edge pulse is release_pulse.
  logic       ce_1ms;
  logic       btn_in;
  logic       btn_level;
  logic       press;
  logic       release_pulse;
  logic       rep;
  logic       ce_out;
  logic [1:0] fsm_state;

  modport master (
    output ce_1ms, btn_in,
    input  btn_level, press, release_pulse, rep, ce_out, fsm_state
  );

  modport slave (
    input  ce_1ms, btn_in,
    output btn_level, press, release_pulse, rep, ce_out, fsm_state
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, tick-timed debounce, press/release
// pulses and a typematic auto-repeat strobe merged into a counter enable.
module btn_conditioner #(
  parameter int DEB_MS       = 4,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100,
  parameter int REP_EN       = 1
) (
  input logic             clk,
  input logic             rst,
  btn_conditioner_if.slave bus
);

  localparam int DW   = $clog2(DEB_MS) + 1;
  localparam int TMAX = (REP_DELAY_MS > REP_RATE_MS) ? REP_DELAY_MS : REP_RATE_MS;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_MS - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REP_DELAY_MS - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REP_RATE_MS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic          s1, s2;
  logic          level;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] timer;
  logic [1:0]    state;
  logic          press_q, release_q, rep_q, ce_q;

  logic          flip, rise_evt, fall_evt, rep_hit;

  // Edge events and the repeat hit are decided on the same edge that updates
  // btn_level, so every strobe leaves the block with zero extra latency.
  always_comb begin
    flip     = (s2 != level) && bus.ce_1ms && (deb_cnt == DEB_LAST);
    rise_evt = flip && !level;
    fall_evt = flip && level;
    rep_hit  = 1'b0;
    if ((REP_EN != 0) && bus.ce_1ms && !fall_evt) begin
      if ((state == DELAY) && (timer == DELAY_LAST))
        rep_hit = 1'b1;
      else if ((state == REPEAT) && (timer == RATE_LAST))
        rep_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 == level) begin
      deb_cnt <= '0;
    end else if (bus.ce_1ms) begin
      if (flip) begin
        level   <= ~level;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Release always wins: it returns the FSM to IDLE even on a repeat tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else if (fall_evt) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((REP_EN != 0) && rise_evt) begin
            state <= DELAY;
            timer <= '0;
          end
        end
        DELAY: begin
          if (bus.ce_1ms) begin
            if (rep_hit) begin
              state <= REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        REPEAT: begin
          if (bus.ce_1ms) begin
            if (rep_hit)
              timer <= '0;
            else
              timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rep_q     <= 1'b0;
      ce_q      <= 1'b0;
    end else begin
      press_q   <= rise_evt;
      release_q <= fall_evt;
      rep_q     <= rep_hit;
      ce_q      <= rise_evt | rep_hit;
    end
  end

  assign bus.btn_level     = level;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.rep           = rep_q;
  assign bus.ce_out        = ce_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: one auto-repeat instance and one press-only
// instance share the stimulus; a tick-level reference model predicts outputs.
module tb_btn_conditioner;

  localparam int DEB = 3;
  localparam int DLY = 5;
  localparam int RTE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_r = 1'b0;
  logic ce_r = 1'b0;

  always #5 clk = ~clk;

  btn_conditioner_if ifa ();
  btn_conditioner_if ifb ();

  assign ifa.btn_in = btn_r;
  assign ifa.ce_1ms = ce_r;
  assign ifb.btn_in = btn_r;
  assign ifb.ce_1ms = ce_r;

  btn_conditioner #(.DEB_MS(DEB), .REP_DELAY_MS(DLY), .REP_RATE_MS(RTE), .REP_EN(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  btn_conditioner #(.DEB_MS(DEB), .REP_DELAY_MS(DLY), .REP_RATE_MS(RTE), .REP_EN(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  // reference model: delay line for the synchronizer, tick counts for the rest
  logic sync_q[$];
  logic m_level = 1'b0;
  int   m_run = 0;
  logic m_hold = 1'b0;
  int   m_held = 0;
  logic e_press, e_rel, e_rep, e_ce;
  logic [1:0] e_state;
  logic coinc_now;

  // expected ce_out pulse per cycle for instance A, consumed at each compare
  logic [0:0] exp_q[$];

  int   phase = 0;
  logic tick_always = 1'b0;

  int a_press_cnt = 0, a_rel_cnt = 0, a_rep_cnt = 0, a_ce_cnt = 0;
  int b_ce_cnt = 0, b_rep_cnt = 0;
  int coinc_hits = 0;
  logic [3:0] cnt4 = 4'd0;
  int p0, r0, c0, q0;
  logic seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic tick);
    logic sv, fell, would;
    e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0; coinc_now = 1'b0;
    fell = 1'b0; would = 1'b0;
    if (rst) begin
      sync_q.delete();
      m_level = 1'b0; m_run = 0; m_hold = 1'b0; m_held = 0;
    end else begin
      sync_q.push_back(b);
      if (sync_q.size() > 3) void'(sync_q.pop_front());
      sv = (sync_q.size() == 3) ? sync_q[0] : 1'b0;
      if (sv == m_level) m_run = 0;
      else if (tick) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = ~m_level;
          m_run = 0;
          if (m_level) e_press = 1'b1;
          else begin e_rel = 1'b1; fell = 1'b1; end
        end
      end
      if (e_press) begin
        m_hold = 1'b1;
        m_held = 0;
      end else if (m_hold) begin
        if (tick) m_held++;
        would = tick && ((m_held == DLY) || (m_held > DLY && ((m_held - DLY) % RTE) == 0));
        if (fell) begin
          m_hold = 1'b0;
          coinc_now = would;
        end else e_rep = would;
      end
    end
    e_ce = e_press | e_rep;
    e_state = !m_hold ? 2'd0 : ((m_held < DLY) ? 2'd1 : 2'd2);
    exp_q.push_back(e_ce);
  endtask

  task automatic step(input logic b);
    logic tick;
    tick = tick_always ? 1'b1 : (phase == 3);
    phase = (phase + 1) % 4;
    btn_r = b;
    ce_r = tick;
    model_step(b, tick);
    @(posedge clk);
    #1;
    chk("a_level", ifa.btn_level, m_level);
    chk("a_press", ifa.press, e_press);
    chk("a_release", ifa.release_pulse, e_rel);
    chk("a_rep", ifa.rep, e_rep);
    chk("a_ce_out", ifa.ce_out, exp_q.pop_front());
    chk("a_state", ifa.fsm_state, e_state);
    chk("b_level", ifb.btn_level, m_level);
    chk("b_press", ifb.press, e_press);
    chk("b_rep", ifb.rep, 1'b0);
    chk("b_ce_out", ifb.ce_out, e_press);
    chk("b_state", ifb.fsm_state, 2'd0);
    if (ifa.press) a_press_cnt++;
    if (ifa.release_pulse) a_rel_cnt++;
    if (ifa.rep) a_rep_cnt++;
    if (ifa.ce_out) begin a_ce_cnt++; cnt4 = cnt4 + 4'd1; end
    if (ifb.ce_out) b_ce_cnt++;
    if (ifb.rep) b_rep_cnt++;
    if (coinc_now && ifa.release_pulse && !ifa.rep) coinc_hits++;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic wait_press(input string tag);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b1);
      if (ifa.press) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    #1;
    // reset held: everything at zero
    run(1'b0, 3);
    run(1'b1, 2);
    chk("rst_level", ifa.btn_level, 1'b0);
    rst = 1'b0;
    run(1'b0, 8);

    // clean press then release
    p0 = a_press_cnt; r0 = a_rel_cnt;
    run(1'b1, 24);
    chk("clean_press_cnt", a_press_cnt - p0, 1);
    chk("clean_no_release", a_rel_cnt - r0, 0);
    run(1'b0, 24);
    chk("clean_release_cnt", a_rel_cnt - r0, 1);

    // bounce: 1 tick high, 1 tick low, then steady
    p0 = a_press_cnt;
    run(1'b1, 4);
    run(1'b0, 4);
    run(1'b1, 40);
    chk("bounce_press_cnt", a_press_cnt - p0, 1);
    run(1'b0, 24);

    // auto-repeat: 20 ticks of hold after press gives 1 press + 8 reps
    cnt4 = 4'd0;
    wait_press("rep_press_seen");
    run(1'b1, 80);
    chk("repeat_cnt4", cnt4, 4'd9);

    // drop now: the release lands exactly on a repeat tick
    q0 = coinc_hits;
    run(1'b0, 24);
    chk("coinc_release", coinc_hits - q0, 1);
    chk("idle_after_rel", ifa.fsm_state, 2'd0);
    c0 = a_ce_cnt;
    run(1'b0, 40);
    chk("no_strobe_after_rel", a_ce_cnt - c0, 0);

    // press-only instance: long hold gives one ce_out
    c0 = b_ce_cnt; r0 = b_rep_cnt;
    run(1'b1, 216);
    chk("b_hold_ce_cnt", b_ce_cnt - c0, 1);
    chk("b_hold_rep_cnt", b_rep_cnt - r0, 0);
    run(1'b0, 24);

    // async reset in the middle of DELAY with the button held
    wait_press("rst_press_seen");
    run(1'b1, 8);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_level", ifa.btn_level, 1'b0);
    chk("arst_ce_out", ifa.ce_out, 1'b0);
    chk("arst_state", ifa.fsm_state, 2'd0);
    chk("arst_b_level", ifb.btn_level, 1'b0);
    run(1'b1, 2);
    rst = 1'b0;
    p0 = a_press_cnt; r0 = a_rep_cnt;
    run(1'b1, 24);
    chk("rst_repress_cnt", a_press_cnt - p0, 1);
    run(1'b1, 24);
    chk("rst_repeat_restart", (a_rep_cnt - r0) > 0, 1'b1);
    run(1'b0, 24);

    // ce_1ms stuck high: timing in clk cycles
    tick_always = 1'b1;
    p0 = a_press_cnt;
    run(1'b1, 30);
    chk("cont_tick_press", a_press_cnt - p0, 1);
    run(1'b0, 20);
    tick_always = 1'b0;

    // randomized bouncing segments
    for (int s = 0; s < 120; s++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
    end
    run(1'b0, 24);
    chk("final_level", ifa.btn_level, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
